// File: rtl/deser_frame_aligner.sv
// Serial receiver: hunts a sync header, then rebuilds each following WIDTH-bit payload.
// A flywheel miss counter holds lock. Define DESER_ERR_CNT_EN to add hdr_err_cnt_o.
module deser_frame_aligner #(
  parameter int                  WIDTH        = 256,
  parameter int                  LOGWIDTH     = 8,
  parameter int                  SYNC_LEN     = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 16'hF628,
  parameter int                  LOSS_THRESH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             locked_o
`ifdef DESER_ERR_CNT_EN
  ,
  output logic [15:0]      hdr_err_cnt_o
`endif
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, HEADER} state_t;

  localparam logic [LOGWIDTH-1:0] LAST_PAYLOAD = LOGWIDTH'(WIDTH - 1);
  localparam logic [LOGWIDTH-1:0] LAST_HEADER  = LOGWIDTH'(SYNC_LEN - 1);
  localparam logic [4:0]          THRESH       = 5'(LOSS_THRESH);

  state_t              r_state, w_stateNext;
  logic [SYNC_LEN-1:0] r_sh, w_shNext;
  logic [LOGWIDTH-1:0] r_cnt;
  logic [3:0]          r_miss;
  logic [4:0]          w_missPlus;
  logic [WIDTH-2:0]    r_payload;
  logic [WIDTH-1:0]    r_data;
  logic                r_valid, r_locked;
  logic                w_match, w_cntClr, w_cntInc, w_emit;
  logic                w_lockSet, w_lockClr, w_missClr, w_missInc, w_hdrErr;

  assign w_shNext   = {r_sh[SYNC_LEN-2:0], data_i};
  assign w_match    = (w_shNext == SYNC_PATTERN);
  assign w_missPlus = {1'b0, r_miss} + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= HUNT;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntClr    = 1'b0;
    w_cntInc    = 1'b0;
    w_emit      = 1'b0;
    w_lockSet   = 1'b0;
    w_lockClr   = 1'b0;
    w_missClr   = 1'b0;
    w_missInc   = 1'b0;
    w_hdrErr    = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_match) begin
          w_stateNext = PAYLOAD;
          w_cntClr    = 1'b1;
          w_lockSet   = 1'b1;
          w_missClr   = 1'b1;
        end
      end
      PAYLOAD: begin
        if (r_cnt == LAST_PAYLOAD) begin
          w_emit      = 1'b1;
          w_stateNext = HEADER;
          w_cntClr    = 1'b1;
        end else begin
          w_cntInc = 1'b1;
        end
      end
      HEADER: begin
        if (r_cnt == LAST_HEADER) begin
          w_cntClr = 1'b1;
          if (w_match) begin
            w_missClr   = 1'b1;
            w_stateNext = PAYLOAD;
          end else begin
            w_hdrErr = 1'b1;
            // Flywheel: keep framing on the expected boundary until the miss budget runs out.
            if (w_missPlus < THRESH) begin
              w_missInc   = 1'b1;
              w_stateNext = PAYLOAD;
            end else begin
              w_missClr   = 1'b1;
              w_lockClr   = 1'b1;
              w_stateNext = HUNT;
            end
          end
        end else begin
          w_cntInc = 1'b1;
        end
      end
      default: w_stateNext = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh      <= '0;
      r_cnt     <= '0;
      r_miss    <= '0;
      r_payload <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_sh    <= w_shNext;
      r_valid <= w_emit;
      // The final payload bit bypasses storage and goes straight into the output word.
      if (r_state == PAYLOAD && !w_emit) r_payload[r_cnt] <= data_i;
      if (w_emit) r_data <= {data_i, r_payload};
      if (w_cntClr)      r_cnt <= '0;
      else if (w_cntInc) r_cnt <= r_cnt + LOGWIDTH'(1);
      if (w_missClr)      r_miss <= '0;
      else if (w_missInc) r_miss <= w_missPlus[3:0];
      if (w_lockSet)      r_locked <= 1'b1;
      else if (w_lockClr) r_locked <= 1'b0;
    end
  end

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign locked_o = r_locked;

`ifdef DESER_ERR_CNT_EN
  logic [15:0] r_errCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_errCnt <= '0;
    else if (w_hdrErr && r_errCnt != 16'hFFFF) r_errCnt <= r_errCnt + 16'd1;
  end

  assign hdr_err_cnt_o = r_errCnt;
`endif

endmodule

// File: tb/tb_deser_frame_aligner.sv
// Bench for deser_frame_aligner: streams are parsed by a frame-level model and compared cycle by cycle.
// Define DESER_ERR_CNT_EN to also check hdr_err_cnt_o.
module tb_deser_frame_aligner;

  localparam int          WIDTH    = 256;
  localparam int          SYNC_LEN = 16;
  localparam logic [15:0] PAT      = 16'hF628;
  localparam int          LOSS     = 4;

  logic             clk;
  logic             reset;
  logic             data_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             locked_o;
`ifdef DESER_ERR_CNT_EN
  logic [15:0]      hdr_err_cnt_o;
`endif

  int nChecks = 0;
  int nFails  = 0;

  bit               stim[$];
  logic             obsValid[$], obsLocked[$];
  logic [WIDTH-1:0] obsData[$];
  int               obsErr[$];
  bit               expValid[$], expLocked[$];
  logic [WIDTH-1:0] expData[$];
  int               expErr[$];

  deser_frame_aligner dut (
    .clk           (clk),
    .reset         (reset),
    .data_i        (data_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .locked_o      (locked_o)
`ifdef DESER_ERR_CNT_EN
    ,
    .hdr_err_cnt_o (hdr_err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pushHeader(input logic [15:0] v);
    for (int k = 15; k >= 0; k--) stim.push_back(v[k]);
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) stim.push_back(w[k]);
  endtask

  task automatic pushBits(input int n, input bit rnd);
    for (int k = 0; k < n; k++) stim.push_back(rnd ? bit'($urandom_range(0, 1)) : 1'b0);
  endtask

  function automatic logic [WIDTH-1:0] randWord();
    logic [WIDTH-1:0] w;
    for (int k = 0; k < WIDTH / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Last 16 stream bits ending at index j, newest in bit 0; bits before reset read as 0.
  function automatic logic [15:0] windowAt(input int j);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < 16; k++)
      if (j - k >= 0 && j - k < stim.size()) w[k] = stim[j-k];
    return w;
  endfunction

  task automatic markLocked(input int a, input int b);
    for (int k = a; k <= b; k++) expLocked[k] = 1'b1;
  endtask

  // Frame-level parse of stim: index i holds what the outputs show right after the edge sampling stim[i].
  task automatic buildModel();
    int n, j, pEnd, hEnd, lockFrom, miss, errs;
    bit done, inFrame;
    logic [WIDTH-1:0] word, held;
    n = stim.size();
    expValid.delete(); expLocked.delete(); expData.delete(); expErr.delete();
    for (int i = 0; i < n; i++) begin
      expValid.push_back(1'b0); expLocked.push_back(1'b0);
      expData.push_back('0);    expErr.push_back(0);
    end
    j = 0;
    done = 1'b0;
    while (!done) begin
      while (j < n && windowAt(j) != PAT) j++;
      if (j >= n) begin
        done = 1'b1;
      end else begin
        lockFrom = j;
        miss = 0;
        inFrame = 1'b1;
        while (inFrame) begin
          pEnd = j + WIDTH;
          hEnd = pEnd + SYNC_LEN;
          if (pEnd >= n) begin
            markLocked(lockFrom, n - 1); done = 1'b1; inFrame = 1'b0;
          end else begin
            for (int k = 0; k < WIDTH; k++) word[k] = stim[j+1+k];
            expValid[pEnd] = 1'b1;
            expData[pEnd]  = word;
            if (hEnd >= n) begin
              markLocked(lockFrom, n - 1); done = 1'b1; inFrame = 1'b0;
            end else if (windowAt(hEnd) == PAT) begin
              miss = 0; j = hEnd;
            end else begin
              expErr[hEnd] = 1;
              miss++;
              if (miss == LOSS) begin
                markLocked(lockFrom, hEnd - 1); j = hEnd + 1; inFrame = 1'b0;
              end else begin
                j = hEnd;
              end
            end
          end
        end
      end
    end
    held = '0;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (expValid[i]) held = expData[i];
      expData[i] = held;
      if (expErr[i] != 0 && errs < 65535) errs++;
      expErr[i] = errs;
    end
  endtask

  task automatic playStream();
    obsValid.delete(); obsLocked.delete(); obsData.delete(); obsErr.delete();
    for (int i = 0; i < stim.size(); i++) begin
      data_i = stim[i];
      @(posedge clk);
      #1;
      obsValid.push_back(valid_o);
      obsLocked.push_back(locked_o);
      obsData.push_back(data_o);
`ifdef DESER_ERR_CNT_EN
      obsErr.push_back(int'(hdr_err_cnt_o));
`else
      obsErr.push_back(0);
`endif
    end
    data_i = 1'b0;
  endtask

  task automatic resetDut();
    data_i = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stim.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    data_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    nChecks += 3;
    if (valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b want 0", valid_o); end
    if (locked_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_locked: got %b want 0", locked_o); end
    if (data_o !== '0) begin nFails++; $display("[TB] FAIL reset_data: got %h want 0", data_o); end
`ifdef DESER_ERR_CNT_EN
    nChecks++;
    if (hdr_err_cnt_o !== 16'd0) begin nFails++; $display("[TB] FAIL reset_errcnt: got %0d want 0", hdr_err_cnt_o); end
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock_alternating();
    bit early;
    int pulses[$];
    logic [WIDTH-1:0] alt;
    alt = {128{2'b10}};
    resetDut();
    do begin
      stim.delete();
      pushBits(37, 1'b1);
      pushHeader(PAT);
      early = 1'b0;
      for (int j = 0; j < 52; j++) if (windowAt(j) == PAT) early = 1'b1;
    end while (early);
    pushWord(alt);
    pushBits(4, 1'b0);
    buildModel();
    playStream();
    for (int i = 0; i < stim.size(); i++) begin
      nChecks += 3;
      if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL alt_valid cyc %0d: got %b want %b", i, obsValid[i], expValid[i]); end
      if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL alt_locked cyc %0d: got %b want %b", i, obsLocked[i], expLocked[i]); end
      if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL alt_data cyc %0d: got %h want %h", i, obsData[i], expData[i]); end
      if (obsValid[i] === 1'b1) pulses.push_back(i);
    end
    nChecks += 3;
    if (obsLocked[51] !== 1'b0 || obsLocked[52] !== 1'b1) begin
      nFails++; $display("[TB] FAIL alt_lock_edge: got %b%b want 01", obsLocked[51], obsLocked[52]);
    end
    if (pulses.size() != 1 || pulses[0] != 308) begin
      nFails++; $display("[TB] FAIL alt_pulse: got %0d pulses want 1 at cycle 308", pulses.size());
    end
    if (obsData[308] !== alt) begin nFails++; $display("[TB] FAIL alt_word: got %h want %h", obsData[308], alt); end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    resetDut();
    pushBits(10, 1'b0);
    for (int f = 1; f <= 3; f++) begin
      pushHeader(PAT);
      pushWord(WIDTH'(f));
    end
    pushBits(4, 1'b0);
    buildModel();
    playStream();
    for (int i = 0; i < stim.size(); i++) begin
      nChecks += 3;
      if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL b2b_valid cyc %0d: got %b want %b", i, obsValid[i], expValid[i]); end
      if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL b2b_locked cyc %0d: got %b want %b", i, obsLocked[i], expLocked[i]); end
      if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL b2b_data cyc %0d: got %h want %h", i, obsData[i], expData[i]); end
      if (obsValid[i] === 1'b1) pulses.push_back(i);
    end
    nChecks++;
    if (pulses.size() != 3) begin
      nFails++; $display("[TB] FAIL b2b_count: got %0d pulses want 3", pulses.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        nChecks += 2;
        if (pulses[f] != 281 + 272 * f) begin nFails++; $display("[TB] FAIL b2b_spacing %0d: got cycle %0d want %0d", f, pulses[f], 281 + 272 * f); end
        if (obsData[pulses[f]] !== WIDTH'(f + 1)) begin nFails++; $display("[TB] FAIL b2b_word %0d: got %h want %0d", f, obsData[pulses[f]], f + 1); end
      end
    end
  endtask

  task automatic test_single_bad_header();
    int pulses[$];
    logic [WIDTH-1:0] w[3];
    resetDut();
    for (int f = 0; f < 3; f++) begin
      w[f] = randWord();
      pushHeader(f == 1 ? 16'h0000 : PAT);
      pushWord(w[f]);
    end
    pushBits(8, 1'b1);
    buildModel();
    playStream();
    for (int i = 0; i < stim.size(); i++) begin
      nChecks += 3;
      if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL bad1_valid cyc %0d: got %b want %b", i, obsValid[i], expValid[i]); end
      if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL bad1_locked cyc %0d: got %b want %b", i, obsLocked[i], expLocked[i]); end
      if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL bad1_data cyc %0d: got %h want %h", i, obsData[i], expData[i]); end
`ifdef DESER_ERR_CNT_EN
      nChecks++;
      if (obsErr[i] !== expErr[i]) begin nFails++; $display("[TB] FAIL bad1_errcnt cyc %0d: got %0d want %0d", i, obsErr[i], expErr[i]); end
`endif
      if (obsValid[i] === 1'b1) pulses.push_back(i);
    end
    nChecks += 2;
    if (obsLocked[287] !== 1'b1) begin nFails++; $display("[TB] FAIL bad1_hold: got %b want 1", obsLocked[287]); end
    if (pulses.size() != 3) begin
      nFails++; $display("[TB] FAIL bad1_count: got %0d pulses want 3", pulses.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        nChecks++;
        if (obsData[pulses[f]] !== w[f]) begin nFails++; $display("[TB] FAIL bad1_word %0d: got %h want %h", f, obsData[pulses[f]], w[f]); end
      end
    end
`ifdef DESER_ERR_CNT_EN
    nChecks++;
    if (obsErr[obsErr.size()-1] != 1) begin nFails++; $display("[TB] FAIL bad1_errfinal: got %0d want 1", obsErr[obsErr.size()-1]); end
`endif
  endtask

  task automatic test_loss_of_lock();
    int pulses[$];
    logic [WIDTH-1:0] w[5];
    resetDut();
    for (int f = 0; f < 4; f++) begin
      w[f] = randWord();
      pushHeader(f == 0 ? PAT : 16'h0000);
      pushWord(w[f]);
    end
    pushHeader(16'h0000);
    pushBits(40, 1'b0);
    w[4] = randWord();
    pushHeader(PAT);
    pushWord(w[4]);
    pushBits(4, 1'b0);
    buildModel();
    playStream();
    for (int i = 0; i < stim.size(); i++) begin
      nChecks += 3;
      if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL loss_valid cyc %0d: got %b want %b", i, obsValid[i], expValid[i]); end
      if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL loss_locked cyc %0d: got %b want %b", i, obsLocked[i], expLocked[i]); end
      if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL loss_data cyc %0d: got %h want %h", i, obsData[i], expData[i]); end
`ifdef DESER_ERR_CNT_EN
      nChecks++;
      if (obsErr[i] !== expErr[i]) begin nFails++; $display("[TB] FAIL loss_errcnt cyc %0d: got %0d want %0d", i, obsErr[i], expErr[i]); end
`endif
      if (obsValid[i] === 1'b1) pulses.push_back(i);
    end
    nChecks += 3;
    if (obsLocked[1102] !== 1'b1 || obsLocked[1103] !== 1'b0) begin
      nFails++; $display("[TB] FAIL loss_drop: got %b%b want 10", obsLocked[1102], obsLocked[1103]);
    end
    if (obsLocked[1158] !== 1'b0 || obsLocked[1159] !== 1'b1) begin
      nFails++; $display("[TB] FAIL loss_relock: got %b%b want 01", obsLocked[1158], obsLocked[1159]);
    end
    if (pulses.size() != 5 || pulses[4] != 1415) begin
      nFails++; $display("[TB] FAIL loss_count: got %0d pulses want 5 ending at cycle 1415", pulses.size());
    end else begin
      for (int f = 0; f < 5; f++) begin
        nChecks++;
        if (obsData[pulses[f]] !== w[f]) begin nFails++; $display("[TB] FAIL loss_word %0d: got %h want %h", f, obsData[pulses[f]], w[f]); end
      end
    end
  endtask

  task automatic test_embedded_pattern();
    int pulses[$];
    logic [WIDTH-1:0] wE, wF;
    resetDut();
    wE = randWord();
    wE[40:25] = PAT;
    wF = randWord();
    pushHeader(PAT); pushWord(wE);
    pushHeader(PAT); pushWord(wF);
    pushBits(4, 1'b0);
    buildModel();
    playStream();
    for (int i = 0; i < stim.size(); i++) begin
      nChecks += 3;
      if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL emb_valid cyc %0d: got %b want %b", i, obsValid[i], expValid[i]); end
      if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL emb_locked cyc %0d: got %b want %b", i, obsLocked[i], expLocked[i]); end
      if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL emb_data cyc %0d: got %h want %h", i, obsData[i], expData[i]); end
      if (obsValid[i] === 1'b1) pulses.push_back(i);
    end
    nChecks++;
    if (pulses.size() != 2 || pulses[0] != 271 || pulses[1] != 543) begin
      nFails++; $display("[TB] FAIL emb_pulses: got %0d pulses want 2 at 271/543", pulses.size());
    end else begin
      nChecks += 2;
      if (obsData[271] !== wE) begin nFails++; $display("[TB] FAIL emb_word0: got %h want %h", obsData[271], wE); end
      if (obsData[543] !== wF) begin nFails++; $display("[TB] FAIL emb_word1: got %h want %h", obsData[543], wF); end
    end
  endtask

  task automatic test_reset_midframe();
    int pulses[$];
    logic [WIDTH-1:0] wA, wC;
    resetDut();
    wA = randWord();
    pushHeader(PAT); pushWord(wA);
    pushHeader(PAT); pushBits(100, 1'b1);
    buildModel();
    playStream();
    for (int i = 0; i < stim.size(); i++) begin
      nChecks += 3;
      if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL mid_valid cyc %0d: got %b want %b", i, obsValid[i], expValid[i]); end
      if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL mid_locked cyc %0d: got %b want %b", i, obsLocked[i], expLocked[i]); end
      if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL mid_data cyc %0d: got %h want %h", i, obsData[i], expData[i]); end
    end
    reset = 1'b1;
    #2;
    nChecks += 3;
    if (valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_valid: got %b want 0", valid_o); end
    if (locked_o !== 1'b0) begin nFails++; $display("[TB] FAIL mid_rst_locked: got %b want 0", locked_o); end
    if (data_o !== '0) begin nFails++; $display("[TB] FAIL mid_rst_data: got %h want 0", data_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stim.delete();
    wC = randWord();
    pushBits(5, 1'b0);
    pushHeader(PAT); pushWord(wC);
    pushBits(4, 1'b0);
    buildModel();
    playStream();
    for (int i = 0; i < stim.size(); i++) begin
      nChecks += 3;
      if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL mid2_valid cyc %0d: got %b want %b", i, obsValid[i], expValid[i]); end
      if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL mid2_locked cyc %0d: got %b want %b", i, obsLocked[i], expLocked[i]); end
      if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL mid2_data cyc %0d: got %h want %h", i, obsData[i], expData[i]); end
      if (obsValid[i] === 1'b1) pulses.push_back(i);
    end
    nChecks++;
    if (pulses.size() != 1 || pulses[0] != 276 || obsData[276] !== wC) begin
      nFails++; $display("[TB] FAIL mid2_word: got %0d pulses, word %h want 1 at 276 with %h", pulses.size(), obsData[276], wC);
    end
  endtask

  task automatic test_random_frames();
    for (int iter = 0; iter < 2; iter++) begin
      resetDut();
      pushBits(20, 1'b1);
      for (int f = 0; f < 8; f++) begin
        pushHeader($urandom_range(0, 2) == 0 ? 16'($urandom) : PAT);
        pushWord(randWord());
      end
      pushBits(4, 1'b0);
      buildModel();
      playStream();
      for (int i = 0; i < stim.size(); i++) begin
        nChecks += 3;
        if (obsValid[i] !== expValid[i]) begin nFails++; $display("[TB] FAIL rnd_valid it%0d cyc %0d: got %b want %b", iter, i, obsValid[i], expValid[i]); end
        if (obsLocked[i] !== expLocked[i]) begin nFails++; $display("[TB] FAIL rnd_locked it%0d cyc %0d: got %b want %b", iter, i, obsLocked[i], expLocked[i]); end
        if (obsData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL rnd_data it%0d cyc %0d: got %h want %h", iter, i, obsData[i], expData[i]); end
`ifdef DESER_ERR_CNT_EN
        nChecks++;
        if (obsErr[i] !== expErr[i]) begin nFails++; $display("[TB] FAIL rnd_errcnt it%0d cyc %0d: got %0d want %0d", iter, i, obsErr[i], expErr[i]); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_alternating();
    test_back_to_back();
    test_single_bad_header();
    test_loss_of_lock();
    test_embedded_pattern();
    test_reset_midframe();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
